// File: rtl/idx_event_buffer_pkg.sv
// idx_event_pkg: shared codes, legal-code range and event record for idx_event_buffer.
package idx_event_pkg;
  localparam logic [7:0] NONE_CODE = 8'hF0;
  localparam logic [7:0] LEGAL_MIN = 8'h00;
  localparam logic [7:0] LEGAL_MAX = 8'h0F;
  parameter int STAMP_W = 8;
  typedef struct packed {
    logic none;
    logic [3:0] idx;
    logic [STAMP_W-1:0] stamp;
  } idx_event_t;
endpackage

// File: rtl/idx_event_buffer_if.sv
// idx_event_buffer_if: valid/ready event readout bus; master is the buffer, slave the consumer.
interface idx_event_buffer_if #(parameter int STAMP_W = 8) ();
  logic ev_valid;
  logic ev_ready;
  logic [3:0] ev_idx;
  logic ev_none;
  logic [STAMP_W-1:0] ev_stamp;
  modport master (output ev_valid, ev_idx, ev_none, ev_stamp, input ev_ready);
  modport slave (input ev_valid, ev_idx, ev_none, ev_stamp, output ev_ready);
endinterface

// File: rtl/idx_event_buffer_fifo.sv
// idx_event_fifo: show-ahead FIFO; head reads as zero when empty, push allowed when full if popping.
module idx_event_fifo import idx_event_pkg::*; #(
  parameter int DEPTH = 8,
  parameter type T = idx_event_t
) (
  input  logic clk,
  input  logic rst_n,
  input  logic push,
  input  T din,
  input  logic pop,
  output T dout,
  output logic full,
  output logic empty,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);
  T mem [DEPTH];
  logic [AW-1:0] wr, rd;
  logic do_push, do_pop;
  assign full = count == (AW+1)'(DEPTH);
  assign empty = count == '0;
  assign do_pop = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout = empty ? '0 : mem[rd];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wr <= '0;
      rd <= '0;
      count <= '0;
    end else begin
      wr <= do_push ? wr + AW'(1) : wr;
      rd <= do_pop ? rd + AW'(1) : rd;
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  always_ff @(posedge clk)
    if (do_push) mem[wr] <= din;
endmodule

// File: rtl/idx_event_buffer.sv
// idx_event_buffer: queues changes of the encoder index code as events for valid/ready readout.
// Define IDX_EVENT_STAMP_EN to add the free-running timestamp carried on ev_stamp.
module idx_event_buffer import idx_event_pkg::*; #(
  parameter int DEPTH = 8,
  parameter int STAMP_W = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic ena,
  input  logic [7:0] code_in,
  input  logic clr_flags,
  idx_event_buffer_if.master ev,
  output logic [$clog2(DEPTH):0] ev_count,
  output logic ovf,
  output logic err
);
`ifdef IDX_EVENT_STAMP_EN
  typedef struct packed {logic none; logic [3:0] idx; logic [STAMP_W-1:0] stamp;} ev_t;
  logic [STAMP_W-1:0] stamp;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) stamp <= '0;
    else if (ena) stamp <= stamp + STAMP_W'(1);
`else
  typedef struct packed {logic none; logic [3:0] idx;} ev_t;
`endif
  ev_t din, head;
  logic [7:0] last_code;
  logic legal, hit, pop, full, empty;
  assign legal = code_in <= LEGAL_MAX || code_in == NONE_CODE;
  assign hit = ena && legal && code_in != last_code;
  assign pop = ev.ev_valid && ev.ev_ready;
  always_comb begin
    din = '0;
    din.none = code_in == NONE_CODE;
    din.idx = code_in[3:0];
`ifdef IDX_EVENT_STAMP_EN
    din.stamp = stamp;
`endif
  end
  // last_code follows every legal change, even a dropped one, so it is not re-detected
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      last_code <= '0;
      ovf <= 1'b0;
      err <= 1'b0;
    end else begin
      if (hit) last_code <= code_in;
      ovf <= (hit && full && !pop) || (ovf && !clr_flags);
      err <= (ena && !legal) || (err && !clr_flags);
    end
  idx_event_fifo #(.DEPTH(DEPTH), .T(ev_t)) u_fifo (
    .clk(clk), .rst_n(rst_n), .push(hit), .din(din), .pop(pop),
    .dout(head), .full(full), .empty(empty), .count(ev_count)
  );
  assign ev.ev_valid = !empty;
  assign ev.ev_idx = head.idx;
  assign ev.ev_none = head.none;
`ifdef IDX_EVENT_STAMP_EN
  assign ev.ev_stamp = head.stamp;
`else
  assign ev.ev_stamp = '0;
`endif
endmodule
